control_caida_cubo: RTL and testbench
=====================================

CONTROL_CAIDA_CUBO -- requirements
Module: control_caida_cubo

Interface
REQ-001 SHALL have parameter ANCHO_PANTALLA, default 640: screen width in pixels.
REQ-002 SHALL have parameter Y_CANASTA, default 440: top row of the basket.
REQ-003 SHALL have parameter ANCHO_CUBO, default 16: cube side in pixels.
REQ-004 SHALL have parameter ANCHO_CANASTA, default 64: basket width in pixels.
REQ-005 SHALL have parameter PASO, default 2: pixels per frame per unit of velocidad.
REQ-006 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-008 SHALL have port tick_frame, input, 1: one-cycle pulse, once per video frame.
REQ-009 SHALL have port iniciar, input, 1: one-cycle spawn request.
REQ-010 SHALL have port x_inicial, input, 10: spawn column.
REQ-011 SHALL have port velocidad, input, 2: speed code from the cube-configuration decoder.
REQ-012 SHALL have port color_in, input, 8: RGB332 colour from the cube-configuration decoder.
REQ-013 SHALL have port canasta_x, input, 10: basket left column, sampled live.
REQ-014 SHALL have outputs cubo_x (10), cubo_y (10), cubo_color (8), activo (1), listo (1), atrapado (1), perdido (1) and puntos (8), all registered.

Function
REQ-015 SHALL implement FSM ESPERA -> CAYENDO -> RESULTADO -> ESPERA.
REQ-016 ESPERA SHALL drive listo=1 and activo=0; iniciar SHALL latch x, velocidad and colour, set cubo_y=0 and enter CAYENDO; activo=1 SHALL appear the next cycle.
REQ-017 x_inicial > ANCHO_PANTALLA-ANCHO_CUBO SHALL be clamped to ANCHO_PANTALLA-ANCHO_CUBO (624).
REQ-018 A latched velocidad of 0 SHALL be treated as 1.
REQ-019 iniciar outside ESPERA SHALL be ignored; the latched values SHALL not change.
REQ-020 In CAYENDO, each tick_frame SHALL compute y_sig = cubo_y + velocidad*PASO, using 11-bit arithmetic with no wrap.
REQ-021 If y_sig < Y_CANASTA-ANCHO_CUBO, cubo_y SHALL become y_sig.
REQ-022 Otherwise cubo_y SHALL clamp to Y_CANASTA-ANCHO_CUBO and the FSM SHALL enter RESULTADO.
REQ-023 On landing, the overlap test SHALL be (cubo_x+ANCHO_CUBO > canasta_x) AND (cubo_x < canasta_x+ANCHO_CANASTA), using the canasta_x value of the landing cycle.
REQ-024 RESULTADO SHALL last exactly one cycle: atrapado=1 if overlap, else perdido=1; never both.
REQ-025 tick_frame in ESPERA or RESULTADO SHALL be ignored.
REQ-026 If iniciar and tick_frame arrive in the same cycle in ESPERA, the spawn SHALL win and no movement occurs.
REQ-027 cubo_x and cubo_color SHALL hold their latched values until the next spawn.

Reset
REQ-028 When rst_n=0 on a clock edge, the FSM SHALL go to ESPERA and drive cubo_x=0, cubo_y=0, cubo_color=0, activo=0, listo=1, atrapado=0, perdido=0, puntos=0.
REQ-029 Reset mid-fall SHALL abandon the cube with no atrapado or perdido pulse.

Configuration
REQ-030 With macro CONTADOR_PUNTOS_EN defined, puntos SHALL increment by 1 on each atrapado cycle and saturate at 255.
REQ-031 Without CONTADOR_PUNTOS_EN, puntos SHALL be constant 0 and no counter flops shall exist.

Structure
REQ-032 Shared package canasta_pkg SHALL hold the FSM state encodings and the screen, basket and cube dimension defaults.
REQ-033 The overlap test SHALL be combinational sub-module comparador_colision (inputs cubo_x and canasta_x, output solapa).

Verification
REQ-034 Catch: x_inicial=100, canasta_x=90, velocidad=3 -> cubo_y=420 after 70 ticks; on tick 71, cubo_y=424, one-cycle atrapado, puntos=1.
REQ-035 Edge overlap: canasta_x=90, x_inicial=75 -> atrapado; x_inicial=74 -> perdido; puntos unchanged on the miss.
REQ-036 Speed 0 and clamp: velocidad=0, x_inicial=700 -> cubo_x=624, step 2 px, landing on tick 212.
REQ-037 Collisions: iniciar+tick in the same cycle -> cubo_y=0; iniciar during CAYENDO -> colour and position unchanged.
REQ-038 Reset: rst_n=0 at cubo_y=200 -> next cycle ESPERA, listo=1, no pulse, puntos=0.
REQ-039 Saturation (CONTADOR_PUNTOS_EN defined): 256 catches -> puntos=255; undefined -> puntos stays 0.

Source files
------------

// File: rtl/canasta_pkg.sv
// Shared definitions for the falling-cube controller: FSM state encoding,
// screen/basket/cube dimension defaults and a column clamp helper.
package canasta_pkg;

  localparam int ANCHO_PANTALLA_DEF = 640;
  localparam int Y_CANASTA_DEF      = 440;
  localparam int ANCHO_CUBO_DEF     = 16;
  localparam int ANCHO_CANASTA_DEF  = 64;
  localparam int PASO_DEF           = 2;

  typedef enum logic [1:0] {
    ESPERA    = 2'd0,
    CAYENDO   = 2'd1,
    RESULTADO = 2'd2
  } estado_t;

  // Keeps a spawn column inside the screen so the whole cube stays visible.
  function automatic logic [9:0] limitar_x(input logic [9:0] x, input logic [9:0] x_max);
    return (x > x_max) ? x_max : x;
  endfunction

endpackage

// File: rtl/comparador_colision.sv
// Combinational horizontal overlap test between the landed cube and the basket.
// Sums are widened to 11 bits so edges near the right screen border never wrap.
module comparador_colision
  import canasta_pkg::*;
#(
  parameter int ANCHO_CUBO    = ANCHO_CUBO_DEF,
  parameter int ANCHO_CANASTA = ANCHO_CANASTA_DEF
) (
  input  logic [9:0] cubo_x,
  input  logic [9:0] canasta_x,
  output logic       solapa
);

  logic [10:0] borde_der_cubo;
  logic [10:0] borde_der_canasta;

  assign borde_der_cubo    = {1'b0, cubo_x} + 11'(ANCHO_CUBO);
  assign borde_der_canasta = {1'b0, canasta_x} + 11'(ANCHO_CANASTA);

  assign solapa = (borde_der_cubo > {1'b0, canasta_x}) &&
                  ({1'b0, cubo_x} < borde_der_canasta);

endmodule

// File: rtl/control_caida_cubo.sv
// Falling-cube controller: spawns a cube on request, drops it once per video
// frame and reports whether it landed in the basket.
// Optional feature: define CONTADOR_PUNTOS_EN to build a saturating catch
// counter on puntos; otherwise puntos is tied to zero.
module control_caida_cubo
  import canasta_pkg::*;
#(
  parameter int ANCHO_PANTALLA = ANCHO_PANTALLA_DEF,
  parameter int Y_CANASTA      = Y_CANASTA_DEF,
  parameter int ANCHO_CUBO     = ANCHO_CUBO_DEF,
  parameter int ANCHO_CANASTA  = ANCHO_CANASTA_DEF,
  parameter int PASO           = PASO_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_frame,
  input  logic       iniciar,
  input  logic [9:0] x_inicial,
  input  logic [1:0] velocidad,
  input  logic [7:0] color_in,
  input  logic [9:0] canasta_x,
  output logic [9:0] cubo_x,
  output logic [9:0] cubo_y,
  output logic [7:0] cubo_color,
  output logic       activo,
  output logic       listo,
  output logic       atrapado,
  output logic       perdido,
  output logic [7:0] puntos
);

  localparam logic [9:0]  X_MAX    = 10'(ANCHO_PANTALLA - ANCHO_CUBO);
  localparam logic [10:0] Y_LIMITE = 11'(Y_CANASTA - ANCHO_CUBO);

  estado_t     estado_q, estado_d;
  logic [9:0]  cubo_x_q, cubo_x_d;
  logic [9:0]  cubo_y_q, cubo_y_d;
  logic [7:0]  color_q, color_d;
  logic [1:0]  vel_q, vel_d;
  logic        listo_q, listo_d;
  logic        activo_q, activo_d;
  logic        atrapado_q, atrapado_d;
  logic        perdido_q, perdido_d;
  logic        solapa;
  logic [10:0] y_sig;

  comparador_colision #(
    .ANCHO_CUBO    (ANCHO_CUBO),
    .ANCHO_CANASTA (ANCHO_CANASTA)
  ) u_comparador (
    .cubo_x    (cubo_x_q),
    .canasta_x (canasta_x),
    .solapa    (solapa)
  );

  // Candidate position for the next frame; 11 bits so a fast step cannot wrap.
  assign y_sig = {1'b0, cubo_y_q} + (11'(vel_q) * 11'(PASO));

  // Next-state and registered-output decode for spawn, fall and landing.
  always_comb begin
    estado_d   = estado_q;
    cubo_x_d   = cubo_x_q;
    cubo_y_d   = cubo_y_q;
    color_d    = color_q;
    vel_d      = vel_q;
    atrapado_d = 1'b0;
    perdido_d  = 1'b0;
    case (estado_q)
      ESPERA: begin
        // A spawn takes priority over any frame tick in the same cycle.
        if (iniciar) begin
          cubo_x_d = limitar_x(x_inicial, X_MAX);
          cubo_y_d = 10'd0;
          color_d  = color_in;
          vel_d    = (velocidad == 2'd0) ? 2'd1 : velocidad;
          estado_d = CAYENDO;
        end
      end
      CAYENDO: begin
        if (tick_frame) begin
          if (y_sig < Y_LIMITE) begin
            cubo_y_d = y_sig[9:0];
          end else begin
            cubo_y_d   = Y_LIMITE[9:0];
            estado_d   = RESULTADO;
            atrapado_d = solapa;
            perdido_d  = ~solapa;
          end
        end
      end
      RESULTADO: begin
        estado_d = ESPERA;
      end
      default: begin
        estado_d = ESPERA;
      end
    endcase
    listo_d  = (estado_d == ESPERA);
    activo_d = (estado_d == CAYENDO);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q   <= ESPERA;
      cubo_x_q   <= 10'd0;
      cubo_y_q   <= 10'd0;
      color_q    <= 8'd0;
      vel_q      <= 2'd1;
      listo_q    <= 1'b1;
      activo_q   <= 1'b0;
      atrapado_q <= 1'b0;
      perdido_q  <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      cubo_x_q   <= cubo_x_d;
      cubo_y_q   <= cubo_y_d;
      color_q    <= color_d;
      vel_q      <= vel_d;
      listo_q    <= listo_d;
      activo_q   <= activo_d;
      atrapado_q <= atrapado_d;
      perdido_q  <= perdido_d;
    end
  end

`ifdef CONTADOR_PUNTOS_EN
  logic [7:0] puntos_q, puntos_d;

  // Catch counter: one point per catch, holding at 255.
  always_comb begin
    puntos_d = puntos_q;
    if (atrapado_d && (puntos_q != 8'hFF)) begin
      puntos_d = puntos_q + 8'd1;
    end
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      puntos_q <= 8'd0;
    end else begin
      puntos_q <= puntos_d;
    end
  end

  assign puntos = puntos_q;
`else
  assign puntos = 8'd0;
`endif

  assign cubo_x     = cubo_x_q;
  assign cubo_y     = cubo_y_q;
  assign cubo_color = color_q;
  assign activo     = activo_q;
  assign listo      = listo_q;
  assign atrapado   = atrapado_q;
  assign perdido    = perdido_q;

endmodule

// File: tb/tb_control_caida_cubo.sv
// Self-checking bench for control_caida_cubo: table of directed drops,
// hand-written corner sequences, randomized drops against a frame-count
// model, and a catch-counter saturation run.
module tb_control_caida_cubo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_frame;
  logic       iniciar;
  logic [9:0] x_inicial;
  logic [1:0] velocidad;
  logic [7:0] color_in;
  logic [9:0] canasta_x;
  logic [9:0] cubo_x;
  logic [9:0] cubo_y;
  logic [7:0] cubo_color;
  logic       activo;
  logic       listo;
  logic       atrapado;
  logic       perdido;
  logic [7:0] puntos;

  int checks = 0;
  int errors = 0;
  int m_puntos = 0;

  localparam int LIMITE = 424;   // Y_CANASTA - ANCHO_CUBO
  localparam int X_MAX  = 624;   // ANCHO_PANTALLA - ANCHO_CUBO

  always #5 clk = ~clk;

  control_caida_cubo dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_frame (tick_frame),
    .iniciar    (iniciar),
    .x_inicial  (x_inicial),
    .velocidad  (velocidad),
    .color_in   (color_in),
    .canasta_x  (canasta_x),
    .cubo_x     (cubo_x),
    .cubo_y     (cubo_y),
    .cubo_color (cubo_color),
    .activo     (activo),
    .listo      (listo),
    .atrapado   (atrapado),
    .perdido    (perdido),
    .puntos     (puntos)
  );

  typedef struct {
    int x;
    int v;
    int bx;
    int exp_x;
    int exp_ticks;
    int exp_res;   // 1 = caught, 2 = missed
  } vec_t;

  vec_t tabla[6];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int clamp_x(input int x);
    return (x > X_MAX) ? X_MAX : x;
  endfunction

  function automatic int paso_px(input int v);
    return ((v == 0) ? 1 : v) * 2;
  endfunction

  function automatic int overlap(input int cx, input int bx);
    return ((cx + 16 > bx) && (cx < bx + 64)) ? 1 : 0;
  endfunction

  function automatic int exp_puntos();
`ifdef CONTADOR_PUNTOS_EN
    return m_puntos;
`else
    return 0;
`endif
  endfunction

  task automatic note_result(input int res);
    if (res == 1 && m_puntos < 255) m_puntos++;
  endtask

  // Spawn one cube and tick every cycle until it lands (bounded).
  task automatic drop(input int x, input int v, input int col, input int bx,
                      output int ticks, output int res, output int yfin);
    int stp;
    stp = paso_px(v);
    iniciar    = 1'b1;
    x_inicial  = 10'(x);
    velocidad  = 2'(v);
    color_in   = 8'(col);
    canasta_x  = 10'(bx);
    tick_frame = 1'b0;
    step();
    iniciar = 1'b0;
    chk("spawn_y", int'(cubo_y), 0);
    chk("spawn_x", int'(cubo_x), clamp_x(x));
    chk("spawn_color", int'(cubo_color), col);
    chk("spawn_activo", int'(activo), 1);
    chk("spawn_listo", int'(listo), 0);
    ticks = 0;
    res   = 0;
    yfin  = 0;
    tick_frame = 1'b1;
    for (int c = 0; c < 600 && res == 0; c++) begin
      step();
      ticks++;
      if (atrapado || perdido) begin
        res  = int'(atrapado) + 2 * int'(perdido);
        yfin = int'(cubo_y);
      end else begin
        chk("fall_y", int'(cubo_y), ticks * stp);
      end
    end
    tick_frame = 1'b0;
    step();
    chk("after_listo", int'(listo), 1);
    chk("after_pulse", int'(atrapado) + int'(perdido), 0);
    note_result(res);
    chk("after_puntos", int'(puntos), exp_puntos());
    $display("drop x=%0d v=%0d bx=%0d ticks=%0d res=%0d y=%0d puntos=%0d",
             x, v, bx, ticks, res, yfin, puntos);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    m_puntos = 0;
  endtask

  initial begin
    int ticks, res, yfin, pulses, stp, t, ov, ex, ecol, done, bx, landing;

    rst_n = 1'b0; tick_frame = 1'b0; iniciar = 1'b0;
    x_inicial = '0; velocidad = '0; color_in = '0; canasta_x = '0;

    tabla[0] = '{x:100, v:3, bx:90,  exp_x:100, exp_ticks:71,  exp_res:1};
    tabla[1] = '{x:75,  v:1, bx:90,  exp_x:75,  exp_ticks:212, exp_res:1};
    tabla[2] = '{x:74,  v:1, bx:90,  exp_x:74,  exp_ticks:212, exp_res:2};
    tabla[3] = '{x:700, v:0, bx:620, exp_x:624, exp_ticks:212, exp_res:1};
    tabla[4] = '{x:0,   v:2, bx:1000,exp_x:0,   exp_ticks:106, exp_res:2};
    tabla[5] = '{x:600, v:3, bx:0,   exp_x:600, exp_ticks:71,  exp_res:2};

    // Reset state
    step();
    step();
    chk("rst_listo", int'(listo), 1);
    chk("rst_activo", int'(activo), 0);
    chk("rst_atrapado", int'(atrapado), 0);
    chk("rst_perdido", int'(perdido), 0);
    chk("rst_x", int'(cubo_x), 0);
    chk("rst_y", int'(cubo_y), 0);
    chk("rst_color", int'(cubo_color), 0);
    chk("rst_puntos", int'(puntos), 0);
    rst_n = 1'b1;
    step();

    // Directed table
    for (int i = 0; i < 6; i++) begin
      drop(tabla[i].x, tabla[i].v, 8'h10 + i, tabla[i].bx, ticks, res, yfin);
      chk("tbl_ticks", ticks, tabla[i].exp_ticks);
      chk("tbl_result", res, tabla[i].exp_res);
      chk("tbl_land_y", yfin, LIMITE);
    end

    // Spawn and tick together in ESPERA, then a second iniciar mid-fall
    iniciar = 1'b1; tick_frame = 1'b1; x_inicial = 10'd300; velocidad = 2'd2;
    color_in = 8'h5A; canasta_x = 10'd0;
    step();
    chk("coll_spawn_y", int'(cubo_y), 0);
    x_inicial = 10'd10; velocidad = 2'd3; color_in = 8'hFF;
    step();
    iniciar = 1'b0;
    chk("coll_x_held", int'(cubo_x), 300);
    chk("coll_color_held", int'(cubo_color), 8'h5A);
    chk("coll_old_step_y", int'(cubo_y), 4);
    res = 0; ticks = 1;
    for (int c = 0; c < 300 && res == 0; c++) begin
      step();
      ticks++;
      if (atrapado || perdido) res = int'(atrapado) + 2 * int'(perdido);
    end
    chk("coll_ticks", ticks, 106);
    chk("coll_result", res, 2);
    tick_frame = 1'b0;
    step();
    $display("collision sequence ticks=%0d res=%0d", ticks, res);

    // Reset in the middle of a fall
    iniciar = 1'b1; x_inicial = 10'd100; velocidad = 2'd1; color_in = 8'h33;
    canasta_x = 10'd90;
    step();
    iniciar = 1'b0; tick_frame = 1'b1;
    for (int c = 0; c < 100; c++) step();
    chk("midfall_y", int'(cubo_y), 200);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    m_puntos = 0;
    chk("midrst_listo", int'(listo), 1);
    chk("midrst_activo", int'(activo), 0);
    chk("midrst_y", int'(cubo_y), 0);
    chk("midrst_puntos", int'(puntos), 0);
    pulses = 0;
    for (int c = 0; c < 250; c++) begin
      step();
      pulses += int'(atrapado) + int'(perdido) + int'(activo) + int'(!listo);
    end
    chk("midrst_no_pulse", pulses, 0);
    tick_frame = 1'b0;
    $display("mid-fall reset sequence pulses=%0d", pulses);

    // Randomized drops against a frame-count model
    for (int n = 0; n < 40; n++) begin
      ex   = clamp_x(int'($urandom_range(0, 1023)));
      ecol = int'($urandom_range(0, 255));
      velocidad = 2'($urandom_range(0, 3));
      stp  = paso_px(int'(velocidad));
      bx   = int'($urandom_range(0, 1023));
      iniciar = 1'b1;
      x_inicial = (ex == X_MAX) ? 10'($urandom_range(624, 1023)) : 10'(ex);
      color_in = 8'(ecol); canasta_x = 10'(bx); tick_frame = 1'($urandom_range(0, 1));
      step();
      chk("rnd_spawn_y", int'(cubo_y), 0);
      chk("rnd_spawn_x", int'(cubo_x), ex);
      t = 0; done = 0; res = 0;
      for (int c = 0; c < 2000 && done == 0; c++) begin
        tick_frame = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) begin
          bx = int'($urandom_range(0, 1023));
          canasta_x = 10'(bx);
        end
        if ($urandom_range(0, 7) == 0) begin
          iniciar = 1'b1;
          x_inicial = 10'($urandom_range(0, 1023));
          velocidad = 2'($urandom_range(0, 3));
          color_in = 8'($urandom_range(0, 255));
        end else begin
          iniciar = 1'b0;
        end
        landing = (tick_frame && (t + 1) * stp >= LIMITE) ? 1 : 0;
        ov = overlap(ex, bx);
        step();
        if (tick_frame) t++;
        if (landing == 1) begin
          chk("rnd_atrapado", int'(atrapado), ov);
          chk("rnd_perdido", int'(perdido), 1 - ov);
          chk("rnd_land_y", int'(cubo_y), LIMITE);
          res = (ov == 1) ? 1 : 2;
          done = 1;
        end else begin
          chk("rnd_y", int'(cubo_y), t * stp);
          chk("rnd_x", int'(cubo_x), ex);
          chk("rnd_color", int'(cubo_color), ecol);
          chk("rnd_activo", int'(activo), 1);
          chk("rnd_no_pulse", int'(atrapado) + int'(perdido), 0);
        end
      end
      if (done == 0) chk("rnd_timeout", 0, 1);
      iniciar = 1'b1; tick_frame = 1'b1;
      step();
      iniciar = 1'b0; tick_frame = 1'b0;
      chk("rnd_after_listo", int'(listo), 1);
      chk("rnd_after_activo", int'(activo), 0);
      chk("rnd_after_pulse", int'(atrapado) + int'(perdido), 0);
      note_result(res);
      chk("rnd_puntos", int'(puntos), exp_puntos());
      $display("random drop %0d x=%0d ticks=%0d res=%0d puntos=%0d", n, ex, t, res, puntos);
    end

    // Counter saturation: 256 catches from a fresh reset
    do_reset();
    for (int n = 0; n < 256; n++) begin
      drop(100, 3, 8'hE0, 90, ticks, res, yfin);
    end
`ifdef CONTADOR_PUNTOS_EN
    chk("sat_puntos", int'(puntos), 255);
`else
    chk("sat_puntos", int'(puntos), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
